sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised successor to the dual-clock `FIFO`, for producer/consumer pairs that share one clock domain, where the gray-code synchronisers add latency and area for no benefit. It adds the following, all absent from `FIFO`:
- Standard and first-word-fall-through (FWFT) read modes.
- Programmable almost-full and almost-empty flags.
- An occupancy count.
- Sticky overflow and underflow error flags.

## Interface
Parameters:
- `DSIZE`, 8, data width in bits.
- `ASIZE`, 3, address width; depth `DEPTH = 1 << ASIZE` (localparam, not overridable).
- `FWFT`, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
- `AFULL_LVL`, `DEPTH-1`, `wafull` asserts when count ≥ `AFULL_LVL`; legal range 1..DEPTH.
- `AEMPTY_LVL`, 1, `raempty` asserts when count ≤ `AEMPTY_LVL`; legal range 0..DEPTH-1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `winc`  in  1  write request.
- `wdata`  in  DSIZE  write data.
- `wfull`  out  1  count == DEPTH.
- `wafull`  out  1  almost full.
- `rinc`  in  1  read request (standard mode) / pop (FWFT mode).
- `rdata`  out  DSIZE  read data.
- `rvalid`  out  1  `rdata` valid.
- `rempty`  out  1  count == 0.
- `raempty`  out  1  almost empty.
- `count`  out  ASIZE+1  current occupancy, 0..DEPTH.
- `clr_err`  in  1  clears `overflow` and `underflow`.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Accept rules:
  - A write is accepted iff `winc && !wfull`.
  - A read is accepted iff `rinc && !rempty`.
  - Both decisions use the flags at the current edge. Acceptance never depends on the other port's action in the same cycle.
- Pointers:
  - `wptr` and `rptr` are ASIZE+1 bits wide and wrap modulo 2^(ASIZE+1). Memory is indexed by the low ASIZE bits.
  - `count = wptr - rptr` modulo 2^(ASIZE+1), held in a register.
- Count update:
  - Accepted write only: +1.
  - Accepted read only: −1.
  - Both accepted, or neither: unchanged.
- Simultaneous requests:
  - When full: the read is accepted, the write is rejected, and `overflow` sets.
  - When empty: the write is accepted, the read is rejected, and `underflow` sets.
- Flags:
  - `wfull`, `wafull`, `rempty` and `raempty` decode from registered `count`. They have no additional combinational path from `winc`/`rinc`.
- Standard mode (`FWFT=0`):
  - An accepted read at edge N drives `rdata = mem[rptr]` and sets `rvalid = 1` for one cycle following edge N.
  - `rdata` holds its value otherwise, and `rvalid` returns to 0.
- FWFT mode (`FWFT=1`):
  - `rdata = mem[rptr]` and `rvalid = !rempty` continuously.
  - `rinc` acknowledges the head word, and the next word appears after the edge.
- Errors:
  - `overflow` and `underflow` set on a rejected request and hold until `clr_err` or `rst` is asserted.
  - If `clr_err` and a new error occur in the same cycle, the set wins.
- Reset:
  - `rst` has priority over all other inputs, including a concurrent `winc`/`rinc`.
  - Reset values: pointers = 0, `count` = 0, `rempty` = 1, `raempty` = 1, `wfull` = 0, `wafull` = 0, `rvalid` = 0, `rdata` = 0, `overflow` = 0, `underflow` = 0.
  - Memory contents are not reset.
  - A mid-operation reset discards all contents at that edge.

## Timing
- Write to read visibility:
  - A write accepted at edge N clears `rempty` in the cycle after edge N.
  - In FWFT mode, the written data is on `rdata` in that same cycle.
  - In standard mode, the earliest `rdata` follows a read accepted at edge N+1 and appears after edge N+1.
- All flags and `count` change only on clock edges, one cycle after the accepted operation.
- Throughput: one write and one read per cycle, sustained, at any occupancy between 1 and DEPTH−1.
- Wrap-around: after 2^(ASIZE+1) writes, the pointer MSBs wrap. `count` arithmetic stays correct with no gaps.

## Structure
- Shared package `fifo_pkg` holds:
  - the `FIFO_MODE_STD`/`FIFO_MODE_FWFT` constants;
  - the pointer-width helper function.
- One sub-module, `fifo_ram`: DEPTH×DSIZE memory with a synchronous write port and an asynchronous read port. The FWFT/standard output stage stays in `sync_fifo`.
- Out-of-range `AFULL_LVL`/`AEMPTY_LVL` values trigger a `$fatal` at elaboration.

## Test plan
All scenarios use DSIZE=8, ASIZE=3.
- **Reset:** after `rst` → `count`=0, `rempty`=1, `raempty`=1, `wfull`=0, `rvalid`=0, `rdata`=0.
- **Fill:** write 0x00..0x07 → `wafull`=1 after the 7th write, `wfull`=1 after the 8th, `count`=8.
  - A 9th write (0xFF) then → `overflow`=1, `count` stays 8.
  - Draining in standard mode returns 0x00..0x07 in order, each with a one-cycle `rvalid` pulse.
- **FWFT:** `FWFT=1`, write 0xA5 at edge N → `rdata`=0xA5 and `rvalid`=1 in the cycle after N. `rinc` → `rempty`=1 after the next edge.
- **Simultaneous requests:**
  - When full: `winc`+`rinc` → `count` goes 8→7, `overflow`=1.
  - When empty: `winc`+`rinc` → `count` goes 0→1, `underflow`=1, data retained.
  - `clr_err` → both error flags = 0.
- **Wrap-around:** 40 interleaved write/read pairs of a random byte stream, occupancy held at 3 → every output matches the scoreboard and `count` stays 3.
- **Mid-operation reset:** reset with `count`=5 while `winc`=1 → `count`=0, `rempty`=1, and the concurrent write is dropped.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO family
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter of sync_fifo.
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointers carry one extra wrap bit above the memory address so that
    // full (count == DEPTH) and empty (count == 0) are distinguishable.
    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DSIZE storage, synchronous write, asynchronous read
//
// Ports:
//   clk     - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data, combinational from i_raddr
//
// Contents are intentionally not reset; occupancy tracking in the parent
// guarantees no location is read before it has been written.
module fifo_ram #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with standard/FWFT read, level flags, count, sticky errors
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   winc      - write request; accepted when !wfull
//   wdata     - write data
//   wfull     - count == DEPTH
//   wafull    - count >= AFULL_LVL
//   rinc      - read request (standard) / pop head word (FWFT); accepted when !rempty
//   rdata     - read data
//   rvalid    - rdata valid (one-cycle pulse in standard mode, !rempty in FWFT mode)
//   rempty    - count == 0
//   raempty   - count <= AEMPTY_LVL
//   count     - occupancy 0..DEPTH
//   clr_err   - clears overflow/underflow (a new error in the same cycle wins)
//   overflow  - sticky: write attempted while full
//   underflow - sticky: read attempted while empty
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 3,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AFULL_LVL  = (1 << ASIZE) - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             wafull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   count,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam int PW    = ptr_width(ASIZE);

    localparam logic [PW-1:0] L_DEPTH  = PW'(DEPTH);
    localparam logic [PW-1:0] L_AFULL  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] L_AEMPTY = PW'(AEMPTY_LVL);
    localparam logic [PW-1:0] L_ONE    = PW'(1);

    if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
        $fatal(1, "sync_fifo: AFULL_LVL out of range 1..DEPTH");
    end
    if ((AEMPTY_LVL < 0) || (AEMPTY_LVL > DEPTH - 1)) begin : g_bad_aempty
        $fatal(1, "sync_fifo: AEMPTY_LVL out of range 0..DEPTH-1");
    end
    if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
        $fatal(1, "sync_fifo: FWFT must be 0 or 1");
    end

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_en;
    logic             w_rd_en;
    logic             w_full;
    logic             w_empty;
    logic [DSIZE-1:0] w_ram_rdata;

    // Flags come only from the registered count, so acceptance of one port
    // never depends on what the other port does in the same cycle.
    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_wr_en = winc && !w_full;
    assign w_rd_en = rinc && !w_empty;

    fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + L_ONE;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + L_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + L_ONE;
                2'b01:   r_count <= r_count - L_ONE;
                default: r_count <= r_count;
            endcase
            // Set has priority over clear so a same-cycle error is never lost.
            r_overflow  <= (winc && w_full)  || (r_overflow  && !clr_err);
            r_underflow <= (rinc && w_empty) || (r_underflow && !clr_err);
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented combinationally; forced to zero while empty
        // so the output never exposes unwritten memory.
        assign rdata  = w_empty ? '0 : w_ram_rdata;
        assign rvalid = !w_empty;
    end else begin : g_std
        logic [DSIZE-1:0] r_rdata;
        logic             r_rvalid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_rd_en;
                if (w_rd_en) begin
                    r_rdata <= w_ram_rdata;
                end
            end
        end

        assign rdata  = r_rdata;
        assign rvalid = r_rvalid;
    end

    assign wfull     = w_full;
    assign wafull    = (r_count >= L_AFULL);
    assign rempty    = w_empty;
    assign raempty   = (r_count <= L_AEMPTY);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo in standard and FWFT modes
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       winc, rinc, clr_err;
    logic [7:0] wdata;
    logic       wfull, wafull, rvalid, rempty, raempty, overflow, underflow;
    logic [7:0] rdata;
    logic [3:0] count;

    logic       f_winc, f_rinc, f_clr;
    logic [7:0] f_wdata;
    logic       f_wfull, f_wafull, f_rvalid, f_rempty, f_raempty, f_overflow, f_underflow;
    logic [7:0] f_rdata;
    logic [3:0] f_count;

    int checks = 0;
    int errors = 0;
    int m_count = 0;
    logic [7:0] sb[$];
    logic [7:0] fq[$];

    sync_fifo #(.DSIZE(8), .ASIZE(3), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull), .wafull(wafull),
        .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty), .raempty(raempty),
        .count(count), .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(3), .FWFT(1)) dut_fw (
        .clk(clk), .rst(rst), .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull), .wafull(f_wafull),
        .rinc(f_rinc), .rdata(f_rdata), .rvalid(f_rvalid), .rempty(f_rempty), .raempty(f_raempty),
        .count(f_count), .clr_err(f_clr), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One standard-mode cycle with scoreboard-based expectations.
    task automatic drive_std(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic       w_acc, r_acc;
        logic [7:0] exp_d;
        w_acc = w && (m_count != 8);
        r_acc = r && (m_count != 0);
        exp_d = 8'h00;
        if (r_acc) exp_d = sb.pop_front();
        if (w_acc) sb.push_back(d);
        m_count = m_count + int'(w_acc) - int'(r_acc);
        @(negedge clk);
        winc = w; wdata = d; rinc = r; clr_err = c;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
        checks++;
        if (count !== 4'(m_count)) begin
            errors++; $display("FAIL count: got %0d expected %0d", count, m_count);
        end
        checks++;
        if (rvalid !== r_acc) begin
            errors++; $display("FAIL rvalid: got %b expected %b", rvalid, r_acc);
        end
        if (r_acc) begin
            checks++;
            if (rdata !== exp_d) begin
                errors++; $display("FAIL rdata: got %02h expected %02h", rdata, exp_d);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 4'd0)  begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
        checks++; if (raempty !== 1'b1) begin errors++; $display("FAIL reset_raempty: got %b expected 1", raempty); end
        checks++; if (wfull !== 1'b0)  begin errors++; $display("FAIL reset_wfull: got %b expected 0", wfull); end
        checks++; if (wafull !== 1'b0) begin errors++; $display("FAIL reset_wafull: got %b expected 0", wafull); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h expected 00", rdata); end
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_err: got %b expected 00", {overflow, underflow});
        end
        checks++; if (f_rempty !== 1'b1) begin errors++; $display("FAIL reset_f_rempty: got %b expected 1", f_rempty); end
        @(negedge clk);
        rst = 1'b0;
        m_count = 0;
        sb.delete();
    endtask

    task automatic test_fwft();
        logic [7:0] vals [3];
        vals[0] = 8'hA5; vals[1] = 8'h11; vals[2] = 8'h22;
        @(negedge clk); f_winc = 1'b1; f_wdata = vals[0]; fq.push_back(vals[0]);
        @(posedge clk); #1; f_winc = 1'b0;
        checks++; if (f_rdata !== fq[0]) begin errors++; $display("FAIL fwft_rdata: got %02h expected %02h", f_rdata, fq[0]); end
        checks++; if (f_rvalid !== 1'b1) begin errors++; $display("FAIL fwft_rvalid: got %b expected 1", f_rvalid); end
        checks++; if (f_rempty !== 1'b0) begin errors++; $display("FAIL fwft_rempty: got %b expected 0", f_rempty); end
        @(negedge clk); f_rinc = 1'b1; void'(fq.pop_front());
        @(posedge clk); #1; f_rinc = 1'b0;
        checks++; if (f_rempty !== 1'b1) begin errors++; $display("FAIL fwft_pop_rempty: got %b expected 1", f_rempty); end
        checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL fwft_pop_rvalid: got %b expected 0", f_rvalid); end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk); f_winc = 1'b1; f_wdata = vals[i]; fq.push_back(vals[i]);
            @(posedge clk); #1; f_winc = 1'b0;
        end
        while (fq.size() > 0) begin
            checks++;
            if (f_rdata !== fq[0]) begin errors++; $display("FAIL fwft_head: got %02h expected %02h", f_rdata, fq[0]); end
            @(negedge clk); f_rinc = 1'b1; void'(fq.pop_front());
            @(posedge clk); #1; f_rinc = 1'b0;
        end
        checks++; if (f_count !== 4'd0) begin errors++; $display("FAIL fwft_count: got %0d expected 0", f_count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            drive_std(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 5) begin
                checks++; if (wafull !== 1'b0) begin errors++; $display("FAIL fill_wafull6: got %b expected 0", wafull); end
            end
            if (i == 6) begin
                checks++; if (wafull !== 1'b1) begin errors++; $display("FAIL fill_wafull7: got %b expected 1", wafull); end
                checks++; if (wfull !== 1'b0)  begin errors++; $display("FAIL fill_wfull7: got %b expected 0", wfull); end
            end
        end
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL fill_wfull8: got %b expected 1", wfull); end
        drive_std(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            drive_std(1'b0, 8'h00, 1'b1, 1'b0);
            drive_std(1'b0, 8'h00, 1'b0, 1'b0);
        end
        checks++; if (rdata !== 8'h07) begin errors++; $display("FAIL fill_hold: got %02h expected 07", rdata); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b expected 1", rempty); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL fill_underflow: got %b expected 0", underflow); end
        drive_std(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_clr: got %b expected 0", overflow); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) drive_std(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        drive_std(1'b1, 8'hEE, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sim_full_overflow: got %b expected 1", overflow); end
        while (m_count > 0) drive_std(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL sim_drained: got %b expected 1", rempty); end
        drive_std(1'b1, 8'h3C, 1'b1, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL sim_empty_underflow: got %b expected 1", underflow); end
        drive_std(1'b0, 8'h00, 1'b1, 1'b0);
        drive_std(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL sim_clr_err: got %b expected 00", {overflow, underflow});
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) drive_std(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive_std(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", count); end
        while (m_count > 0) drive_std(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) drive_std(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1; winc = 1'b1; wdata = 8'h99;
        @(posedge clk); #1;
        rst = 1'b0; winc = 1'b0;
        m_count = 0;
        sb.delete();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mrst_count: got %0d expected 0", count); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL mrst_rempty: got %b expected 1", rempty); end
        drive_std(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL mrst_dropped: got %b expected 1", underflow); end
        drive_std(1'b1, 8'h77, 1'b0, 1'b1);
        drive_std(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        f_winc = 1'b0; f_rinc = 1'b0; f_clr = 1'b0; f_wdata = 8'h00;
        test_reset();
        test_fwft();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
